// File: rtl/spi_controller.sv
// Single-write SPI master: 16-bit mode-0 frames, MSB first, launched from a valid/ready port.
// SCLK runs at clk/(2*CLK_DIV); each phase is CLK_DIV cycles so a 2-flop synchroniser can follow.
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    generate
        if (CLK_DIV < 4 || CS_GAP < 4) begin : g_bad_params
            $error("spi_controller: CLK_DIV and CS_GAP must both be >= 4");
        end
    endgenerate

    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(CS_GAP);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   shift_q, shift_d;
    logic          ncs_q, sclk_q, copi_q, ready_q, busy_q, done_q;
    logic          div_last;

    assign div_last = (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    shift_d = {cmd_write, cmd_addr, cmd_data};
                    bit_d   = 4'd0;
                    div_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_LOW, S_HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    gap_d   = '0;
                    state_d = (state_q == S_HOLD) ? S_GAP : S_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        // Shift at the end of HIGH so COPI moves with the falling edge.
                        shift_d = {shift_q[14:0], 1'b0};
                        bit_d   = bit_q + 4'd1;
                        state_d = S_LOW;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(CS_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            ncs_q   <= !(state_d inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});
            sclk_q  <= (state_d == S_HIGH);
            copi_q  <= (state_d == S_IDLE || state_d == S_GAP) ? 1'b0 : shift_d[15];
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_GAP) && (state_d == S_IDLE);
        end
    end

    assign nCS       = ncs_q;
    assign SCLK      = sclk_q;
    assign COPI      = copi_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
